// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/flush sequencer.
package pipe_pkg;

    localparam int REG_AW_DEFAULT = 6;

    localparam int SB_EX    = 0;
    localparam int SB_MEM   = 1;
    localparam int SB_WB    = 2;
    localparam int SB_DEPTH = 3;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_STALL
    } state_e;

endpackage

// File: rtl/hz_scoreboard.sv
// Three-entry destination scoreboard (EX, MEM, WB) with two source-match ports.
module hz_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kill_i,
    input  logic              push_v_i,
    input  logic [REG_AW-1:0] push_rd_i,
    input  logic [REG_AW-1:0] ra_i,
    input  logic [REG_AW-1:0] rb_i,
    output logic              ra_match_o,
    output logic              rb_match_o
);

    logic [SB_DEPTH-1:0] sb_v_q;
    logic [SB_DEPTH-1:0] sb_v_d;
    logic [REG_AW-1:0]   sb_rd_q [SB_DEPTH];

    // A redirect lets the MEM instruction retire into WB but squashes EX.
    always_comb begin
        sb_v_d         = '0;
        sb_v_d[SB_WB]  = sb_v_q[SB_MEM];
        sb_v_d[SB_MEM] = sb_v_q[SB_EX] & ~kill_i;
        sb_v_d[SB_EX]  = push_v_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_v_q <= '0;
        end else begin
            sb_v_q <= sb_v_d;
        end
    end

    // NOTE: destination fields carry no reset; they are qualified by sb_v_q,
    // so clearing them would only add reset fan-out.
    always_ff @(posedge clk) begin
        sb_rd_q[SB_WB]  <= sb_rd_q[SB_MEM];
        sb_rd_q[SB_MEM] <= sb_rd_q[SB_EX];
        sb_rd_q[SB_EX]  <= push_rd_i;
    end

    always_comb begin
        ra_match_o = 1'b0;
        rb_match_o = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_v_q[i] && (sb_rd_q[i] == ra_i)) ra_match_o = 1'b1;
            if (sb_v_q[i] && (sb_rd_q[i] == rb_i)) rb_match_o = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard stall and branch-flush sequencer for a 5-stage pipeline without forwarding.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              mem_redirect,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              exmem_flush,
    output logic              stall,
    output logic [1:0]        stall_cnt,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    state_e           state_q;
    logic             id_valid_q;
    logic [1:0]       stall_cnt_q;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_events_q;

    logic rs_match;
    logic rt_match;
    logic running;
    logic redirect;
    logic hz;
    logic push_v;

    assign running  = (state_q == S_RUN) || (state_q == S_STALL);
    assign redirect = running & mem_redirect;
    // WB counts as a source because the register file writes at the edge.
    assign hz       = running & id_valid_q &
                      ((id_uses_rs & rs_match) | (id_uses_rt & rt_match));
    assign push_v   = running & ~mem_redirect & ~hz & id_valid_q & id_regwrite;

    hz_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .kill_i     (redirect),
        .push_v_i   (push_v),
        .push_rd_i  (id_rd),
        .ra_i       (id_rs),
        .rb_i       (id_rt),
        .ra_match_o (rs_match),
        .rb_match_o (rt_match)
    );

    // NOTE: every output gets a default before the branches so no path
    // leaves one unassigned and infers a latch.
    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        stall       = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (state_q == S_INIT) begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (mem_redirect) begin
            pc_we       = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (hz) begin
            idex_bubble = 1'b1;
            stall       = 1'b1;
        end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_INIT;
            id_valid_q     <= 1'b0;
            stall_cnt_q    <= '0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    id_valid_q <= 1'b1;
                    state_q    <= S_RUN;
                end
                default: begin
                    if (mem_redirect) begin
                        id_valid_q     <= 1'b0;
                        state_q        <= S_RUN;
                        stall_cnt_q    <= '0;
                        flush_events_q <= flush_events_q + CNT_W'(1);
                    end else if (hz) begin
                        state_q        <= S_STALL;
                        stall_cnt_q    <= stall_cnt_q + 2'd1;
                        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
                    end else begin
                        id_valid_q  <= 1'b1;
                        state_q     <= S_RUN;
                        stall_cnt_q <= '0;
                    end
                end
            endcase
        end
    end

    assign stall_cnt    = rst ? 2'd0 : stall_cnt_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  id_rs = '0;
    logic [5:0]  id_rt = '0;
    logic        id_uses_rs = 1'b0;
    logic        id_uses_rt = 1'b0;
    logic [5:0]  id_rd = '0;
    logic        id_regwrite = 1'b0;
    logic        mem_redirect = 1'b0;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, stall;
    logic [1:0]  stall_cnt;
    logic [31:0] stall_cycles, flush_events;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .mem_redirect (mem_redirect),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .exmem_flush  (exmem_flush),
        .stall        (stall),
        .stall_cnt    (stall_cnt),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] rs, input logic [5:0] rt, input logic urs,
                         input logic urt, input logic [5:0] rd, input logic rw);
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_rd = rd; id_regwrite = rw; mem_redirect = 1'b0;
    endtask

    // Leaves the DUT in its first S_RUN cycle with idle (non-writing) ID inputs.
    task automatic do_reset();
        issue(6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        issue(6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        checks++; if (pc_we !== 1'b0) begin errors++; $display("FAIL rst_pc_we got %0b want 0", pc_we); end
        checks++; if (ifid_we !== 1'b0) begin errors++; $display("FAIL rst_ifid_we got %0b want 0", ifid_we); end
        checks++; if (ifid_flush !== 1'b1) begin errors++; $display("FAIL rst_ifid_flush got %0b want 1", ifid_flush); end
        checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL rst_idex_bubble got %0b want 1", idex_bubble); end
        checks++; if (exmem_flush !== 1'b1) begin errors++; $display("FAIL rst_exmem_flush got %0b want 1", exmem_flush); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", stall); end
        checks++; if (stall_cnt !== 2'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_stall_cycles got %0d want 0", stall_cycles); end
        checks++; if (flush_events !== 32'd0) begin errors++; $display("FAIL rst_flush_events got %0d want 0", flush_events); end
        rst = 1'b0;
        #1;
        checks++; if (pc_we !== 1'b1) begin errors++; $display("FAIL init_pc_we got %0b want 1", pc_we); end
        checks++; if (ifid_we !== 1'b1) begin errors++; $display("FAIL init_ifid_we got %0b want 1", ifid_we); end
        checks++; if (ifid_flush !== 1'b0) begin errors++; $display("FAIL init_ifid_flush got %0b want 0", ifid_flush); end
        checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL init_idex_bubble got %0b want 1", idex_bubble); end
        checks++; if (exmem_flush !== 1'b1) begin errors++; $display("FAIL init_exmem_flush got %0b want 1", exmem_flush); end
        tick();
        for (int k = 1; k <= 5; k++) begin
            issue(6'(9 + k), 6'(9 + k), 1'b1, 1'b1, 6'(k), 1'b1);
            #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL run_stall instr %0d got %0b want 0", k, stall); end
            checks++; if (pc_we !== 1'b1 || idex_bubble !== 1'b0) begin errors++; $display("FAIL run_enables instr %0d got pc_we=%0b bubble=%0b want 1/0", k, pc_we, idex_bubble); end
            tick();
        end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL run_stall_cycles got %0d want 0", stall_cycles); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(6'd0, 6'd0, 1'b0, 1'b0, 6'd7, 1'b1);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_producer_stall got %0b want 0", stall); end
        tick();
        issue(6'd7, 6'd0, 1'b1, 1'b0, 6'd8, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            #1;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall cycle %0d got %0b want 1", i, stall); end
            checks++; if (pc_we !== 1'b0 || ifid_we !== 1'b0 || idex_bubble !== 1'b1) begin errors++; $display("FAIL b2b_enables cycle %0d got pc_we=%0b ifid_we=%0b bubble=%0b want 0/0/1", i, pc_we, ifid_we, idex_bubble); end
            tick();
            checks++; if (stall_cnt !== 2'(i)) begin errors++; $display("FAIL b2b_stall_cnt got %0d want %0d", stall_cnt, i); end
        end
        #1;
        checks++; if (stall !== 1'b0 || pc_we !== 1'b1) begin errors++; $display("FAIL b2b_release got stall=%0b pc_we=%0b want 0/1", stall, pc_we); end
        tick();
        checks++; if (stall_cycles !== 32'd3) begin errors++; $display("FAIL b2b_stall_cycles got %0d want 3", stall_cycles); end
        checks++; if (stall_cnt !== 2'd0) begin errors++; $display("FAIL b2b_stall_cnt_clear got %0d want 0", stall_cnt); end
    endtask

    task automatic test_distance(input int between, input logic uses, input int exp_stalls);
        int n;
        do_reset();
        issue(6'd0, 6'd0, 1'b0, 1'b0, 6'd9, 1'b1);
        tick();
        for (int j = 0; j < between; j++) begin
            issue(6'd20, 6'd21, 1'b1, 1'b1, 6'd30, 1'b1);
            tick();
        end
        issue(6'd0, 6'd9, 1'b0, uses, 6'd31, 1'b0);
        n = 0;
        #1;
        while (stall === 1'b1 && n < 8) begin
            n++;
            tick();
            #1;
        end
        checks++; if (n !== exp_stalls) begin errors++; $display("FAIL dist%0d_uses%0b stall cycles got %0d want %0d", between, uses, n, exp_stalls); end
        tick();
        checks++; if (stall_cycles !== 32'(exp_stalls)) begin errors++; $display("FAIL dist%0d_uses%0b stall_cycles got %0d want %0d", between, uses, stall_cycles, exp_stalls); end
    endtask

    task automatic test_redirect();
        do_reset();
        issue(6'd0, 6'd0, 1'b0, 1'b0, 6'd4, 1'b1);
        tick();
        issue(6'd20, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0);
        mem_redirect = 1'b1;
        #1;
        checks++; if (ifid_flush !== 1'b1 || idex_bubble !== 1'b1 || exmem_flush !== 1'b1) begin errors++; $display("FAIL redir_flushes got %0b%0b%0b want 111", ifid_flush, idex_bubble, exmem_flush); end
        checks++; if (pc_we !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL redir_pc_stall got pc_we=%0b stall=%0b want 1/0", pc_we, stall); end
        tick();
        mem_redirect = 1'b0;
        checks++; if (flush_events !== 32'd1) begin errors++; $display("FAIL redir_flush_events got %0d want 1", flush_events); end
        issue(6'd4, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL redir_consumer cycle %0d got stall %0b want 0", i, stall); end
            tick();
        end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL redir_stall_cycles got %0d want 0", stall_cycles); end
    endtask

    task automatic test_redirect_in_stall();
        do_reset();
        issue(6'd0, 6'd0, 1'b0, 1'b0, 6'd7, 1'b1);
        tick();
        issue(6'd7, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstall_first got %0b want 1", stall); end
        tick();
        mem_redirect = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || ifid_flush !== 1'b1 || pc_we !== 1'b1) begin errors++; $display("FAIL rstall_cancel got stall=%0b flush=%0b pc_we=%0b want 0/1/1", stall, ifid_flush, pc_we); end
        tick();
        mem_redirect = 1'b0;
        checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL rstall_stall_cycles got %0d want 1", stall_cycles); end
        checks++; if (flush_events !== 32'd1) begin errors++; $display("FAIL rstall_flush_events got %0d want 1", flush_events); end
        checks++; if (stall_cnt !== 2'd0) begin errors++; $display("FAIL rstall_stall_cnt got %0d want 0", stall_cnt); end
        #1;
        checks++; if (stall !== 1'b0 || pc_we !== 1'b1 || idex_bubble !== 1'b0) begin errors++; $display("FAIL rstall_run got stall=%0b pc_we=%0b bubble=%0b want 0/1/0", stall, pc_we, idex_bubble); end
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        issue(6'd0, 6'd0, 1'b0, 1'b0, 6'd7, 1'b1);
        tick();
        issue(6'd7, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0);
        tick();
        checks++; if (stall_cnt !== 2'd1) begin errors++; $display("FAIL mrst_pre_cnt got %0d want 1", stall_cnt); end
        rst = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || stall_cnt !== 2'd0 || pc_we !== 1'b0 || ifid_flush !== 1'b1) begin errors++; $display("FAIL mrst_outputs got stall=%0b cnt=%0d pc_we=%0b flush=%0b want 0/0/0/1", stall, stall_cnt, pc_we, ifid_flush); end
        tick();
        rst = 1'b0;
        checks++; if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin errors++; $display("FAIL mrst_counters got %0d/%0d want 0/0", stall_cycles, flush_events); end
        tick();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mrst_consumer got stall %0b want 0", stall); end
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_distance(1, 1'b1, 2);
        test_distance(2, 1'b1, 1);
        test_distance(3, 1'b1, 0);
        test_distance(0, 1'b0, 0);
        test_redirect();
        test_redirect_in_stall();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and flush sequencer for the 5-stage pipelined datapath (IF, ID, EX, MEM, WB).
- The datapath has no forwarding, so this block keeps its own 3-entry destination scoreboard (EX, MEM, WB) and stalls the ID instruction until no older in-flight write targets its sources.
- It squashes the three younger stages when a branch or jump resolves in MEM.
- It drives the PC and pipeline-buffer enables and flushes, and keeps stall and flush event counters.

## Interface
Parameters
- `REG_AW`, 6: register-address width (64 registers).
- `CNT_W`, 32: performance-counter width.

Ports
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `id_rs`  in  REG_AW: ID-stage source register 1.
- `id_rt`  in  REG_AW: ID-stage source register 2.
- `id_uses_rs`  in  1: ID instruction reads rs.
- `id_uses_rt`  in  1: ID instruction reads rt.
- `id_rd`  in  REG_AW: ID instruction destination.
- `id_regwrite`  in  1: ID instruction writes a register (RegWrite control bit).
- `mem_redirect`  in  1: taken branch (pc_sel) or jump resolved in MEM this cycle.
- `pc_we`  out  1: PC load enable.
- `ifid_we`  out  1: IF/ID load enable.
- `ifid_flush`  out  1: clear IF/ID to bubble.
- `idex_bubble`  out  1: load a bubble (all control zero) into ID/EX.
- `exmem_flush`  out  1: clear EX/MEM control to zero.
- `stall`  out  1: hazard stall active.
- `stall_cnt`  out  2: consecutive stall cycles for the current ID instruction.
- `stall_cycles`  out  CNT_W: total stall cycles since reset.
- `flush_events`  out  CNT_W: total redirects since reset.

## Operation
- State registers:
  - FSM `{S_INIT, S_RUN, S_STALL}`.
  - `id_valid`.
  - Scoreboard entries `sb_v[2:0]` and `sb_rd[2:0]`, where index 0 is EX, 1 is MEM and 2 is WB.
- The register file writes at the clock edge, so a WB-stage write is not visible to a same-cycle ID read. WB therefore counts as a hazard source.
- Hazard condition:
  - `hz = id_valid & ((id_uses_rs & match(id_rs)) | (id_uses_rt & match(id_rt)))`.
  - `match(r)` = any i with `sb_v[i] & sb_rd[i]==r`.
  - Register 0 is not exempt.
- Priority is redirect > hazard > run.
- Redirect (`mem_redirect=1` in S_RUN or S_STALL):
  - Outputs: `ifid_flush=1`, `idex_bubble=1`, `exmem_flush=1`, `pc_we=1`, `stall=0`.
  - Next state: `sb_v[2]<=sb_v[1]`, `sb_v[1]<=0`, `sb_v[0]<=0`, `id_valid<=0`, state<=S_RUN, `stall_cnt<=0`.
  - `flush_events` increments.
- Hazard (no redirect, `hz=1`):
  - Outputs: `pc_we=0`, `ifid_we=0`, `idex_bubble=1`, `stall=1`.
  - Scoreboard shifts with the EX entry invalid.
  - state<=S_STALL, `stall_cnt` increments, `stall_cycles` increments.
- Run (no redirect, `hz=0`):
  - Outputs: `pc_we=1`, `ifid_we=1`.
  - Scoreboard shifts: EX entry <= `{id_valid & id_regwrite, id_rd}`.
  - `id_valid<=1`, state<=S_RUN, `stall_cnt<=0`.
- S_INIT (first cycle after reset release):
  - Outputs: `pc_we=1`, `ifid_we=1`, `ifid_flush=0`, `idex_bubble=1`, `exmem_flush=1`.
  - `id_valid<=1`, then go to S_RUN.
- Counters wrap modulo 2^CNT_W.
- Invariant: `stall_cnt` never exceeds 3. The worst case is a producer immediately ahead, which drains through EX, MEM and WB.

## Timing
- While `rst=1`:
  - Outputs: `pc_we=0`, `ifid_we=0`, `ifid_flush=1`, `idex_bubble=1`, `exmem_flush=1`, `stall=0`, `stall_cnt=0`.
  - Counters are 0, `sb_v=0`, `id_valid=0`.
  - Next state is S_INIT.
- Outputs are combinational from registered state plus current ID inputs and `mem_redirect` (Mealy). All state updates happen on the rising edge.
- Dependent-instruction penalty:
  - Back-to-back producer/consumer: 3 stall cycles.
  - One instruction between them: 2.
  - Two between them: 1.
  - Three or more: 0.
- `mem_redirect` asserted during a stall cancels the stall in that same cycle, and the stalled instruction is squashed.
- `rst` asserted mid-stall or mid-redirect takes effect at the next edge and overrides everything.

## Structure
- Package `pipe_pkg`:
  - State enum.
  - Scoreboard index constants `SB_EX`, `SB_MEM`, `SB_WB`.
  - `REG_AW` default.
- One sub-module, `hz_scoreboard`: holds the 3-entry shift register and provides the `match()` comparators for two read ports.
- FSM, enables and counters stay in the top module.

## Test plan
- Reset then run:
  - Release `rst`; one S_INIT cycle with `idex_bubble=1`.
  - Then 5 independent instructions (`id_rd`=1..5, sources 10..14) give `stall=0` every cycle and `stall_cycles=0`.
- Back-to-back RAW:
  - Producer `rd=7, regwrite=1`, next instruction `rs=7, uses_rs=1`.
  - Required: exactly 3 cycles with `stall=1`, `pc_we=0`, `stall_cnt` 1→2→3, then release; `stall_cycles=3`.
- Distance RAW:
  - One unrelated instruction between producer (`rd=9`) and consumer (`rt=9`) gives 2 stall cycles.
  - Two between gives 1. Three between gives 0.
  - Consumer with `uses_rt=0` gives 0.
- Redirect:
  - `mem_redirect=1` for one cycle with EX entry valid (`rd=4`).
  - Required: `ifid_flush`, `idex_bubble`, `exmem_flush` all 1 that cycle; `flush_events=1`.
  - A following consumer of r4 does not stall.
- Redirect during stall:
  - In the 2nd stall cycle, assert `mem_redirect`.
  - Required: `stall=0` that cycle, state S_RUN next, `stall_cycles=1`, `flush_events=1`.
- Mid-operation reset:
  - Assert `rst` during a stall.
  - Required: next cycle all counters 0, `sb_v=0`, and a consumer of the old destination does not stall.
